// File: rtl/la_ppv_recv_pkg.sv
// Shared widths, constants and helpers for the lookahead PPV link receiver.
// Port-vector layout: bit i = output port i, bit 4 = local eject.
package la_ppv_recv_pkg;

  localparam int NUM_PORT       = 5;
  localparam int PC_INDEX_WIDTH = 3;
  localparam int DST_WIDTH      = 4;
  localparam int DST_LIST_WIDTH = 16;
  localparam int BUNDLE_W       = NUM_PORT * 4;
  localparam int CNT_W          = 16;

  localparam logic [PC_INDEX_WIDTH-1:0] LOCAL_DIR = 3'd4;
  localparam logic [NUM_PORT-1:0]       PPV_EJECT = 5'b10000;

  typedef struct packed {
    logic [DST_WIDTH-1:0]      dst;
    logic [DST_LIST_WIDTH-1:0] dst_list;
    logic                      mc;
    logic [PC_INDEX_WIDTH-1:0] src_indir;
    logic [BUNDLE_W-1:0]       next_ppv;
  } flit_hdr_t;

  function automatic logic [2:0] ppv_popcount(input logic [NUM_PORT-1:0] ppv);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_PORT; i++) n = n + {2'b00, ppv[i]};
    return n;
  endfunction

endpackage

// File: rtl/la_ppv_recv_ppv_slice_sel.sv
// Picks the PPV slice that applies at this router out of the upstream bundle
// and flags malformed bundles. Purely combinational.
module ppv_slice_sel
  import la_ppv_recv_pkg::*;
#(
  parameter int LINK_OUT_DIR = 0
) (
  input  logic [BUNDLE_W-1:0]       bundle,
  input  logic [PC_INDEX_WIDTH-1:0] src_indir,
  output logic [NUM_PORT-1:0]       ppv,
  output logic [2:0]                prod_cnt,
  output logic                      v_bad_src,
  output logic                      v_uturn,
  output logic                      v_zero
);

  localparam logic [1:0] LOD = 2'(LINK_OUT_DIR);

  logic [1:0] sel;

  always_comb begin
    // Wraps mod 4 on purpose; slice 3 is the U-turn slot the upstream zeroes.
    if (src_indir == LOCAL_DIR) sel = LOD;
    else                        sel = LOD - src_indir[1:0] - 2'd1;

    ppv = '0;
    unique case (sel)
      2'd0: ppv = bundle[4*NUM_PORT-1:3*NUM_PORT];
      2'd1: ppv = bundle[3*NUM_PORT-1:2*NUM_PORT];
      2'd2: ppv = bundle[2*NUM_PORT-1:NUM_PORT];
      2'd3: ppv = bundle[NUM_PORT-1:0];
      default: ppv = '0;
    endcase

    prod_cnt  = ppv_popcount(ppv);
    v_bad_src = src_indir > LOCAL_DIR;
    v_uturn   = (src_indir != LOCAL_DIR) && (sel == 2'd3);
    v_zero    = (ppv == '0);
  end

endmodule

// File: rtl/la_ppv_recv.sv
// Link-side receiver: registers the incoming flit, extracts this router's PPV
// from the lookahead bundle and tracks malformed-bundle errors.
module la_ppv_recv
  import la_ppv_recv_pkg::*;
#(
  parameter int LINK_OUT_DIR = 0,
  parameter int PAYLOAD_W    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lnk_valid,
  input  logic [DST_WIDTH-1:0]      lnk_dst,
  input  logic [DST_LIST_WIDTH-1:0] lnk_dstList,
  input  logic                      lnk_mc,
  input  logic [PC_INDEX_WIDTH-1:0] lnk_srcIndir,
  input  logic [BUNDLE_W-1:0]       lnk_nextPPV,
  input  logic [PAYLOAD_W-1:0]      lnk_payload,
  input  logic                      err_clr,
  output logic                      out_valid,
  output logic [DST_WIDTH-1:0]      out_dst,
  output logic [DST_LIST_WIDTH-1:0] out_dstList,
  output logic                      out_mc,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [NUM_PORT-1:0]       out_ppv,
  output logic [2:0]                out_prodCnt,
  output logic                      out_eject,
  output logic                      err_sticky,
  output logic [CNT_W-1:0]          err_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic                 vld_p1;
  flit_hdr_t            hdr_p1;
  logic [PAYLOAD_W-1:0] payload_p1;

  // Stage 1: link capture; data holds across bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      hdr_p1     <= '0;
      payload_p1 <= '0;
    end else begin
      vld_p1 <= lnk_valid;
      if (lnk_valid) begin
        hdr_p1     <= '{dst: lnk_dst, dst_list: lnk_dstList, mc: lnk_mc,
                        src_indir: lnk_srcIndir, next_ppv: lnk_nextPPV};
        payload_p1 <= lnk_payload;
      end
    end
  end

  logic [NUM_PORT-1:0] sel_ppv;
  logic [2:0]          sel_cnt;
  logic                v_bad_src, v_uturn, v_zero;

  ppv_slice_sel #(.LINK_OUT_DIR(LINK_OUT_DIR)) u_sel (
    .bundle    (hdr_p1.next_ppv),
    .src_indir (hdr_p1.src_indir),
    .ppv       (sel_ppv),
    .prod_cnt  (sel_cnt),
    .v_bad_src (v_bad_src),
    .v_uturn   (v_uturn),
    .v_zero    (v_zero)
  );

  logic                viol_p1;
  logic [NUM_PORT-1:0] ppv_fix;
  logic [2:0]          cnt_fix;

  always_comb begin
    viol_p1 = vld_p1 & (v_bad_src | v_uturn | (v_zero & ~hdr_p1.mc));
    ppv_fix = viol_p1 ? PPV_EJECT : sel_ppv;
    cnt_fix = viol_p1 ? 3'd1 : sel_cnt;
  end

  // Stage 2: allocator-facing registers; held while no flit arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_dst     <= '0;
      out_dstList <= '0;
      out_mc      <= 1'b0;
      out_payload <= '0;
      out_ppv     <= '0;
      out_prodCnt <= '0;
      out_eject   <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_dst     <= hdr_p1.dst;
        out_dstList <= hdr_p1.dst_list;
        out_mc      <= hdr_p1.mc;
        out_payload <= payload_p1;
        out_ppv     <= ppv_fix;
        out_prodCnt <= cnt_fix;
        out_eject   <= ppv_fix[NUM_PORT-1];
      end
    end
  end

  // A violation landing on the clearing cycle is kept, not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (err_clr) begin
      err_sticky <= viol_p1;
      err_cnt    <= viol_p1 ? CNT_W'(1) : '0;
    end else if (viol_p1) begin
      err_sticky <= 1'b1;
      err_cnt    <= sat_inc(err_cnt);
    end
  end

endmodule
